booth_share_ctrl: RTL

- Controller that shares one sequential Booth multiplier core between two requesters.
- Arbitrates round-robin, latches the granted operands, and issues a start pulse to the core.
- Waits for the core's done, with a watchdog timeout, then returns the product tagged with the requester id.
- Sits between the switch/LED FPGA front-end and the multiplier datapath.

---
 rtl/booth_share_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/booth_share_ctrl.sv
// Shares one sequential Booth multiplier core between two requesters.
// Round-robin grant, operand latch, start pulse, watchdog on the core's done,
// and a one-cycle tagged response.
module booth_share_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic [1:0]           req_ready,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic                 last_q;       // requester granted most recently
  logic                 id_q;         // owner of the job in flight
  logic [TW-1:0]        timer_q;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic                 rsp_id_q, rsp_err_q;
  logic [2*WIDTH-1:0]   rsp_product_q;

  logic                 accept;
  logic                 grant_id;
  logic                 timeout_hit;

  assign accept      = |req_ready;
  assign grant_id    = req_ready[1];
  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // Round-robin grant, only offered while idle and out of reset
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && !rst) begin
      unique case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_q ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mul_done || timeout_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state_q != StIdle);
    mul_start = (state_q == StIssue);
    rsp_valid = (state_q == StResp);
  end

  // Operand latch, watchdog timer and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q        <= 1'b1;  // so requester 0 wins the first contested grant
      id_q          <= 1'b0;
      timer_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      rsp_id_q      <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opa_q  <= grant_id ? req_a1 : req_a0;
            opb_q  <= grant_id ? req_b1 : req_b0;
            id_q   <= grant_id;
            last_q <= grant_id;
          end
        end
        StIssue: timer_q <= '0;
        StWait: begin
          timer_q <= timer_q + 1'b1;
          if (mul_done) begin
            rsp_product_q <= mul_product;
            rsp_err_q     <= 1'b0;
            rsp_id_q      <= id_q;
          end else if (timeout_hit) begin
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b1;
            rsp_id_q      <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;
  assign rsp_id           = rsp_id_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_product      = rsp_product_q;

endmodule
